// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA sprite pixel stage.
// Geometry defaults, RGB444 colour constants and the sync bundle carried down the pipe.
package vga_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int RGB_W  = 12;
  localparam int SPR_W  = 64;
  localparam int SPR_H  = 64;
  localparam int POS_W  = 11;
  localparam int ADDR_W = 12;

  localparam logic [RGB_W-1:0] BG_COLOR   = 12'h00F;
  localparam logic [RGB_W-1:0] TRANSP_KEY = 12'hF0F;
  localparam logic [RGB_W-1:0] BLACK      = 12'h000;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b0};

  // True when lo <= c < lo + w; positions are 11 bits so lo + w never wraps.
  function automatic logic in_span(input logic [POS_W-1:0] c,
                                   input logic [POS_W-1:0] lo,
                                   input int               w);
    return (c >= lo) && (c < lo + POS_W'(w));
  endfunction

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: bounces between 0 and MAX, stepping by speed on each frame tick.
// Updates only on tick with enable=1 and speed!=0; otherwise position and direction hold.
module sprite_axis
  import vga_pkg::*;
#(
  parameter int MAX  = 576,
  parameter int INIT = 0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic [2:0]       speed,
  output logic [POS_W-1:0] pos,
  output logic             dir
);

  localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX);
  localparam logic [POS_W-1:0] INIT_P = POS_W'(INIT);

  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic [POS_W-1:0] step;

  assign step = POS_W'(speed);

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick && enable && (speed != 3'd0)) begin
      if (dir_q == DIR_INC) begin
        if (pos_q + step >= MAX_P) begin
          pos_d = MAX_P;
          dir_d = DIR_DEC;
        end else begin
          pos_d = pos_q + step;
        end
      end else begin
        if (pos_q <= step) begin
          pos_d = '0;
          dir_d = DIR_INC;
        end else begin
          pos_d = pos_q - step;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pos_q <= INIT_P;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_sprite_mover.sv
// Sprite pixel stage behind the 640x480 timing controller: 3-cycle latency, 1 pixel/cycle.
// No backpressure; sync/valid are delayed 3 cycles to stay aligned with vga_rgb.
module vga_sprite_mover
  import vga_pkg::*;
#(
  parameter int          H_RES      = vga_pkg::H_RES,
  parameter int          V_RES      = vga_pkg::V_RES,
  parameter int          SPR_W      = vga_pkg::SPR_W,
  parameter int          SPR_H      = vga_pkg::SPR_H,
  parameter int          INIT_X     = 0,
  parameter int          INIT_Y     = 0,
  parameter logic [11:0] BG_COLOR   = vga_pkg::BG_COLOR,
  parameter logic [11:0] TRANSP_KEY = vga_pkg::TRANSP_KEY
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        enable,
  input  logic [2:0]  speed,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] vga_rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        valid_o
);

  logic             vsync_prev_q, vsync_prev_d;
  logic             tick;
  logic [POS_W-1:0] x_pos, y_pos;
  logic             dir_x, dir_y;

  logic [POS_W-1:0] h_pix, v_pix, rel_x, rel_y;
  logic             hit;

  logic              inside_q, inside_d;
  logic              inside2_q, inside2_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  sync_t             sync1_q, sync1_d;
  sync_t             sync2_q, sync2_d;
  sync_t             sync3_q, sync3_d;

  // Falling vsync lands in vertical blanking, so position is stable across the active frame.
  assign tick = vsync_prev_q & ~vsync;

  sprite_axis #(
    .MAX  (H_RES - SPR_W),
    .INIT (INIT_X)
  ) u_axis_x (
    .pclk   (pclk),
    .reset  (reset),
    .tick   (tick),
    .enable (enable),
    .speed  (speed),
    .pos    (x_pos),
    .dir    (dir_x)
  );

  sprite_axis #(
    .MAX  (V_RES - SPR_H),
    .INIT (INIT_Y)
  ) u_axis_y (
    .pclk   (pclk),
    .reset  (reset),
    .tick   (tick),
    .enable (enable),
    .speed  (speed),
    .pos    (y_pos),
    .dir    (dir_y)
  );

  assign h_pix = POS_W'(h_cnt);
  assign v_pix = POS_W'(v_cnt);
  assign rel_x = h_pix - x_pos;
  assign rel_y = v_pix - y_pos;
  assign hit   = valid & in_span(h_pix, x_pos, SPR_W) & in_span(v_pix, y_pos, SPR_H);

  always_comb begin
    vsync_prev_d = vsync;
    inside_d     = hit;
    inside2_d    = inside_q;
    rom_addr_d   = '0;
    if (hit) begin
      rom_addr_d = ADDR_W'(rel_y) * ADDR_W'(SPR_W) + ADDR_W'(rel_x);
    end
    sync1_d = '{hsync: hsync, vsync: vsync, valid: valid};
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // ROM data for the stage-2 pixel arrives this cycle, alongside sync2_q/inside2_q.
  always_comb begin
    rgb_d = BLACK;
    if (sync2_q.valid) begin
      if (inside2_q && (rom_data != TRANSP_KEY)) begin
        rgb_d = rom_data;
      end else begin
        rgb_d = BG_COLOR;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      vsync_prev_q <= 1'b1;
      inside_q     <= 1'b0;
      inside2_q    <= 1'b0;
      rom_addr_q   <= '0;
      rgb_q        <= BLACK;
      sync1_q      <= SYNC_IDLE;
      sync2_q      <= SYNC_IDLE;
      sync3_q      <= SYNC_IDLE;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      inside_q     <= inside_d;
      inside2_q    <= inside2_d;
      rom_addr_q   <= rom_addr_d;
      rgb_q        <= rgb_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign vga_rgb  = rgb_q;
  assign hsync_o  = sync3_q.hsync;
  assign vsync_o  = sync3_q.vsync;
  assign valid_o  = sync3_q.valid;

endmodule
